// File: rtl/axi_ram_pkg.sv
// Shared types and constants for the AXI RAM slave: FSM states, response and burst codes, bus structs.
package axi_ram_pkg;

    localparam int AXI_DW  = 32;
    localparam int AXI_AW  = 16;
    localparam int AXI_IDW = 5;
    localparam int AXI_IDR = 5;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    typedef struct packed {
        logic [AXI_IDW-1:0]  awid;
        logic [AXI_AW-1:0]   awaddr;
        logic [7:0]          awlen;
        logic [2:0]          awsize;
        logic [1:0]          awburst;
        logic                awvalid;
        logic [AXI_DW-1:0]   wdata;
        logic [AXI_DW/8-1:0] wstrb;
        logic                wlast;
        logic                wvalid;
        logic                bready;
        logic [AXI_IDR-1:0]  arid;
        logic [AXI_AW-1:0]   araddr;
        logic [7:0]          arlen;
        logic [2:0]          arsize;
        logic [1:0]          arburst;
        logic                arvalid;
        logic                rready;
    } axi_mosi_t;

    typedef struct packed {
        logic                awready;
        logic                wready;
        logic [AXI_IDW-1:0]  bid;
        logic [1:0]          bresp;
        logic                bvalid;
        logic                arready;
        logic [AXI_IDR-1:0]  rid;
        logic [AXI_DW-1:0]   rdata;
        logic [1:0]          rresp;
        logic                rlast;
        logic                rvalid;
    } axi_miso_t;

endpackage

// File: rtl/axi_ram_if.sv
// Bundles the master-to-slave and slave-to-master AXI structs of one mesh link.
interface axi_ram_if;
    import axi_ram_pkg::*;

    axi_mosi_t mosi;
    axi_miso_t miso;

    modport master (output mosi, input miso);
    modport slave  (input mosi, output miso);
endinterface

// File: rtl/axi_ram_addr_gen.sv
// Next beat address: steps by the (clamped) transfer size unless the burst is FIXED.
module axi_ram_addr_gen
    import axi_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [2:0]            size_i,
    input  logic [1:0]            burst_i,
    output logic [ADDR_WIDTH-1:0] next_addr_o
);
    localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);

    logic [2:0] eff_size;

    always_comb begin
        eff_size = (size_i > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : size_i;
        // WRAP and reserved encodings simply increment; the sum wraps at the address width
        if (burst_i == BURST_FIXED) begin
            next_addr_o = addr_i;
        end else begin
            next_addr_o = addr_i + (ADDR_WIDTH'(1) << eff_size);
        end
    end
endmodule

// File: rtl/axi_ram_slave.sv
// AXI memory slave with independent write and read FSMs over a byte-enabled word array.
// Optional beat counters (wr_beats_o/rd_beats_o) are built when AXI_RAM_STATS_EN is defined.
module axi_ram_slave
    import axi_ram_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int ID_W_WIDTH     = 5,
    parameter int ID_R_WIDTH     = 5,
    parameter int MEM_DEPTH      = 256
) (
    input  logic      ACLK,
    input  logic      ARESET,
    input  axi_mosi_t s_axi_i,
    output axi_miso_t s_axi_o
`ifdef AXI_RAM_STATS_EN
    ,
    output logic [31:0] wr_beats_o,
    output logic [31:0] rd_beats_o
`endif
);
    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam longint unsigned MEM_BYTES = longint'(MEM_DEPTH) * longint'(STRB_W);

    logic [AXI_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    w_state_e              w_state_q, w_state_d;
    logic [ID_W_WIDTH-1:0] awid_q, awid_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d, waddr_next;
    logic [7:0]            awlen_q, awlen_d;
    logic [2:0]            awsize_q, awsize_d;
    logic [1:0]            awburst_q, awburst_d;
    logic [8:0]            wcnt_q, wcnt_d;
    logic                  werr_q, werr_d;

    r_state_e              r_state_q, r_state_d;
    logic [ID_R_WIDTH-1:0] arid_q, arid_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d, raddr_next;
    logic [7:0]            arlen_q, arlen_d;
    logic [2:0]            arsize_q, arsize_d;
    logic [1:0]            arburst_q, arburst_d;
    logic [7:0]            rcnt_q, rcnt_d;

    logic awready, wready, bvalid, mem_we;
    logic arready, rvalid, rlast;
    logic w_in_range, r_in_range;
    logic [IDX_W-1:0]          widx, ridx;
    logic [AXI_DATA_WIDTH-1:0] wdata_in, wmask, rdata;
    logic [STRB_W-1:0]         wstrb_in;

    assign wdata_in = s_axi_i.wdata[AXI_DATA_WIDTH-1:0];
    assign wstrb_in = s_axi_i.wstrb[STRB_W-1:0];

    generate
        for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
            assign wmask[gi*8 +: 8] = {8{wstrb_in[gi]}};
        end
    endgenerate

    assign w_in_range = 64'(waddr_q) < MEM_BYTES;
    assign r_in_range = 64'(raddr_q) < MEM_BYTES;
    assign widx       = IDX_W'(waddr_q >> OFF_W);
    assign ridx       = IDX_W'(raddr_q >> OFF_W);
    // Combinational read sees the array before this cycle's write lands
    assign rdata      = r_in_range ? mem_q[ridx] : '0;

    axi_ram_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(AXI_DATA_WIDTH)) u_waddr_gen (
        .addr_i      (waddr_q),
        .size_i      (awsize_q),
        .burst_i     (awburst_q),
        .next_addr_o (waddr_next)
    );

    axi_ram_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(AXI_DATA_WIDTH)) u_raddr_gen (
        .addr_i      (raddr_q),
        .size_i      (arsize_q),
        .burst_i     (arburst_q),
        .next_addr_o (raddr_next)
    );

    always_comb begin
        w_state_d = w_state_q;
        awid_d    = awid_q;
        waddr_d   = waddr_q;
        awlen_d   = awlen_q;
        awsize_d  = awsize_q;
        awburst_d = awburst_q;
        wcnt_d    = wcnt_q;
        werr_d    = werr_q;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                awready = 1'b1;
                if (s_axi_i.awvalid) begin
                    awid_d    = s_axi_i.awid[ID_W_WIDTH-1:0];
                    waddr_d   = s_axi_i.awaddr[ADDR_WIDTH-1:0];
                    awlen_d   = s_axi_i.awlen;
                    awsize_d  = s_axi_i.awsize;
                    awburst_d = s_axi_i.awburst;
                    wcnt_d    = '0;
                    werr_d    = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                wready = 1'b1;
                if (s_axi_i.wvalid) begin
                    // Surplus beats past AWLEN are swallowed without touching memory
                    if (wcnt_q <= {1'b0, awlen_q}) begin
                        if (w_in_range) begin
                            mem_we = 1'b1;
                        end else begin
                            werr_d = 1'b1;
                        end
                        wcnt_d  = wcnt_q + 9'd1;
                        waddr_d = waddr_next;
                    end
                    if (s_axi_i.wlast) begin
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (s_axi_i.bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        arid_d    = arid_q;
        raddr_d   = raddr_q;
        arlen_d   = arlen_q;
        arsize_d  = arsize_q;
        arburst_d = arburst_q;
        rcnt_d    = rcnt_q;
        arready   = 1'b0;
        rvalid    = 1'b0;
        rlast     = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                arready = 1'b1;
                if (s_axi_i.arvalid) begin
                    arid_d    = s_axi_i.arid[ID_R_WIDTH-1:0];
                    raddr_d   = s_axi_i.araddr[ADDR_WIDTH-1:0];
                    arlen_d   = s_axi_i.arlen;
                    arsize_d  = s_axi_i.arsize;
                    arburst_d = s_axi_i.arburst;
                    rcnt_d    = '0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                rvalid = 1'b1;
                rlast  = (rcnt_q == arlen_q);
                if (s_axi_i.rready) begin
                    if (rlast) begin
                        r_state_d = R_IDLE;
                    end else begin
                        rcnt_d  = rcnt_q + 8'd1;
                        raddr_d = raddr_next;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_q <= W_IDLE;
            awid_q    <= '0;
            waddr_q   <= '0;
            awlen_q   <= '0;
            awsize_q  <= '0;
            awburst_q <= '0;
            wcnt_q    <= '0;
            werr_q    <= 1'b0;
            r_state_q <= R_IDLE;
            arid_q    <= '0;
            raddr_q   <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
            rcnt_q    <= '0;
        end else begin
            w_state_q <= w_state_d;
            awid_q    <= awid_d;
            waddr_q   <= waddr_d;
            awlen_q   <= awlen_d;
            awsize_q  <= awsize_d;
            awburst_q <= awburst_d;
            wcnt_q    <= wcnt_d;
            werr_q    <= werr_d;
            r_state_q <= r_state_d;
            arid_q    <= arid_d;
            raddr_q   <= raddr_d;
            arlen_q   <= arlen_d;
            arsize_q  <= arsize_d;
            arburst_q <= arburst_d;
            rcnt_q    <= rcnt_d;
        end
    end

    // Storage survives reset, so it has no reset branch
    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            mem_q[widx] <= (mem_q[widx] & ~wmask) | (wdata_in & wmask);
        end
    end

    always_comb begin
        s_axi_o         = '0;
        s_axi_o.awready = awready;
        s_axi_o.wready  = wready;
        s_axi_o.bvalid  = bvalid;
        s_axi_o.bid     = AXI_IDW'(awid_q);
        s_axi_o.bresp   = werr_q ? RESP_SLVERR : RESP_OKAY;
        s_axi_o.arready = arready;
        s_axi_o.rvalid  = rvalid;
        s_axi_o.rlast   = rlast;
        s_axi_o.rid     = AXI_IDR'(arid_q);
        s_axi_o.rdata   = rvalid ? AXI_DW'(rdata) : '0;
        s_axi_o.rresp   = (rvalid && !r_in_range) ? RESP_SLVERR : RESP_OKAY;
    end

`ifdef AXI_RAM_STATS_EN
    logic [31:0] wr_beats_q, rd_beats_q;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_beats_q <= '0;
            rd_beats_q <= '0;
        end else begin
            if (s_axi_i.wvalid && wready) begin
                wr_beats_q <= wr_beats_q + 32'd1;
            end
            if (rvalid && s_axi_i.rready) begin
                rd_beats_q <= rd_beats_q + 32'd1;
            end
        end
    end

    assign wr_beats_o = wr_beats_q;
    assign rd_beats_o = rd_beats_q;
`endif

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed self-checking bench for axi_ram_slave; one task per scenario.
module tb_axi_ram_slave;
    import axi_ram_pkg::*;

    logic ACLK = 1'b0;
    logic ARESET;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 ACLK = ~ACLK;

    axi_ram_if bus ();

`ifdef AXI_RAM_STATS_EN
    logic [31:0] wr_beats, rd_beats;
`endif

    axi_ram_slave #(
        .AXI_DATA_WIDTH (32),
        .ADDR_WIDTH     (16),
        .ID_W_WIDTH     (5),
        .ID_R_WIDTH     (5),
        .MEM_DEPTH      (256)
    ) dut (
        .ACLK    (ACLK),
        .ARESET  (ARESET),
        .s_axi_i (bus.mosi),
        .s_axi_o (bus.miso)
`ifdef AXI_RAM_STATS_EN
        ,
        .wr_beats_o (wr_beats),
        .rd_beats_o (rd_beats)
`endif
    );

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_aw(input logic [4:0] id, input logic [15:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        bus.mosi.awid    = id;
        bus.mosi.awaddr  = addr;
        bus.mosi.awlen   = len;
        bus.mosi.awsize  = size;
        bus.mosi.awburst = burst;
        bus.mosi.awvalid = 1'b1;
        for (int i = 0; i < 50 && !bus.miso.awready; i++) tick();
        if (!bus.miso.awready) begin
            n_checks++; n_fail++;
            $display("FAIL aw_timeout: awready=%0b required 1", bus.miso.awready);
        end
        tick();
        bus.mosi.awvalid = 1'b0;
    endtask

    task automatic do_ar(input logic [4:0] id, input logic [15:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        bus.mosi.arid    = id;
        bus.mosi.araddr  = addr;
        bus.mosi.arlen   = len;
        bus.mosi.arsize  = size;
        bus.mosi.arburst = burst;
        bus.mosi.arvalid = 1'b1;
        for (int i = 0; i < 50 && !bus.miso.arready; i++) tick();
        if (!bus.miso.arready) begin
            n_checks++; n_fail++;
            $display("FAIL ar_timeout: arready=%0b required 1", bus.miso.arready);
        end
        tick();
        bus.mosi.arvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        bus.mosi.wdata  = data;
        bus.mosi.wstrb  = strb;
        bus.mosi.wlast  = last;
        bus.mosi.wvalid = 1'b1;
        for (int i = 0; i < 50 && !bus.miso.wready; i++) tick();
        if (!bus.miso.wready) begin
            n_checks++; n_fail++;
            $display("FAIL w_timeout: wready=%0b required 1", bus.miso.wready);
        end
        tick();
        bus.mosi.wvalid = 1'b0;
        bus.mosi.wlast  = 1'b0;
    endtask

    task automatic get_b(output logic [4:0] id, output logic [1:0] resp);
        for (int i = 0; i < 50 && !bus.miso.bvalid; i++) tick();
        if (!bus.miso.bvalid) begin
            n_checks++; n_fail++;
            $display("FAIL b_timeout: bvalid=%0b required 1", bus.miso.bvalid);
        end
        id   = bus.miso.bid;
        resp = bus.miso.bresp;
        bus.mosi.bready = 1'b1;
        tick();
        bus.mosi.bready = 1'b0;
    endtask

    task automatic get_r(output logic [31:0] data, output logic [1:0] resp);
        bus.mosi.rready = 1'b1;
        for (int i = 0; i < 50 && !bus.miso.rvalid; i++) tick();
        if (!bus.miso.rvalid) begin
            n_checks++; n_fail++;
            $display("FAIL r_timeout: rvalid=%0b required 1", bus.miso.rvalid);
        end
        data = bus.miso.rdata;
        resp = bus.miso.rresp;
        tick();
        bus.mosi.rready = 1'b0;
    endtask

    task automatic write_word(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                              output logic [1:0] resp);
        logic [4:0] id;
        do_aw(5'd0, addr, 8'd0, 3'd2, BURST_INCR);
        do_w(data, strb, 1'b1);
        get_b(id, resp);
    endtask

    task automatic read_word(input logic [15:0] addr, output logic [31:0] data, output logic [1:0] resp);
        do_ar(5'd0, addr, 8'd0, 3'd2, BURST_INCR);
        get_r(data, resp);
    endtask

    task automatic test_reset();
        bus.mosi = '0;
        ARESET = 1'b1;
        repeat (3) tick();
        ARESET = 1'b0;
        #1;
        n_checks++; if (bus.miso.awready !== 1'b1) begin n_fail++; $display("FAIL rst_awready: got %0b want 1", bus.miso.awready); end
        n_checks++; if (bus.miso.arready !== 1'b1) begin n_fail++; $display("FAIL rst_arready: got %0b want 1", bus.miso.arready); end
        n_checks++; if (bus.miso.wready  !== 1'b0) begin n_fail++; $display("FAIL rst_wready: got %0b want 0", bus.miso.wready); end
        n_checks++; if (bus.miso.bvalid  !== 1'b0) begin n_fail++; $display("FAIL rst_bvalid: got %0b want 0", bus.miso.bvalid); end
        n_checks++; if (bus.miso.rvalid  !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %0b want 0", bus.miso.rvalid); end
        n_checks++; if (bus.miso.rlast   !== 1'b0) begin n_fail++; $display("FAIL rst_rlast: got %0b want 0", bus.miso.rlast); end
        n_checks++; if (bus.miso.bresp   !== 2'b00) begin n_fail++; $display("FAIL rst_bresp: got %0h want 0", bus.miso.bresp); end
        n_checks++; if (bus.miso.rresp   !== 2'b00) begin n_fail++; $display("FAIL rst_rresp: got %0h want 0", bus.miso.rresp); end
        n_checks++; if (bus.miso.bid     !== 5'd0) begin n_fail++; $display("FAIL rst_bid: got %0h want 0", bus.miso.bid); end
        n_checks++; if (bus.miso.rid     !== 5'd0) begin n_fail++; $display("FAIL rst_rid: got %0h want 0", bus.miso.rid); end
        $display("reset: checks done");
    endtask

    task automatic test_incr_write();
        logic [4:0] id;
        logic [1:0] resp;
        do_aw(5'd5, 16'h0010, 8'd3, 3'd2, BURST_INCR);
        n_checks++; if (bus.miso.awready !== 1'b0) begin n_fail++; $display("FAIL incr_aw_blocked: got %0b want 0", bus.miso.awready); end
        n_checks++; if (bus.miso.wready !== 1'b1) begin n_fail++; $display("FAIL incr_wready: got %0b want 1", bus.miso.wready); end
        do_w(32'h11111111, 4'hF, 1'b0);
        do_w(32'h22222222, 4'hF, 1'b0);
        do_w(32'h33333333, 4'hF, 1'b0);
        do_w(32'h44444444, 4'hF, 1'b1);
        n_checks++; if (bus.miso.awready !== 1'b0) begin n_fail++; $display("FAIL incr_aw_before_b: got %0b want 0", bus.miso.awready); end
        get_b(id, resp);
        n_checks++; if (id !== 5'd5) begin n_fail++; $display("FAIL incr_bid: got %0h want 5", id); end
        n_checks++; if (resp !== RESP_OKAY) begin n_fail++; $display("FAIL incr_bresp: got %0h want 0", resp); end
        n_checks++; if (bus.miso.awready !== 1'b1) begin n_fail++; $display("FAIL incr_aw_after_b: got %0b want 1", bus.miso.awready); end
        $display("incr_write: id=%0h bresp=%0h", id, resp);
    endtask

    task automatic test_incr_read_stall();
        logic [31:0] exp_data [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        logic [31:0] first;
        bus.mosi.rready = 1'b0;
        do_ar(5'd3, 16'h0010, 8'd3, 3'd2, BURST_INCR);
        for (int b = 0; b < 4; b++) begin
            n_checks++; if (bus.miso.rvalid !== 1'b1) begin n_fail++; $display("FAIL rd_rvalid beat %0d: got %0b want 1", b, bus.miso.rvalid); end
            n_checks++; if (bus.miso.rdata !== exp_data[b]) begin n_fail++; $display("FAIL rd_data beat %0d: got %08h want %08h", b, bus.miso.rdata, exp_data[b]); end
            n_checks++; if (bus.miso.rlast !== (b == 3)) begin n_fail++; $display("FAIL rd_rlast beat %0d: got %0b want %0b", b, bus.miso.rlast, (b == 3)); end
            n_checks++; if (bus.miso.rid !== 5'd3) begin n_fail++; $display("FAIL rd_rid beat %0d: got %0h want 3", b, bus.miso.rid); end
            n_checks++; if (bus.miso.rresp !== RESP_OKAY) begin n_fail++; $display("FAIL rd_rresp beat %0d: got %0h want 0", b, bus.miso.rresp); end
            first = bus.miso.rdata;
            tick();
            n_checks++; if (bus.miso.rdata !== exp_data[b] || bus.miso.rvalid !== 1'b1) begin n_fail++; $display("FAIL rd_stall beat %0d: got %08h/%0b want %08h/1", b, bus.miso.rdata, bus.miso.rvalid, exp_data[b]); end
            bus.mosi.rready = 1'b1;
            tick();
            bus.mosi.rready = 1'b0;
            $display("incr_read: beat %0d data=%08h", b, first);
        end
        n_checks++; if (bus.miso.rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_done_rvalid: got %0b want 0", bus.miso.rvalid); end
        n_checks++; if (bus.miso.arready !== 1'b1) begin n_fail++; $display("FAIL rd_done_arready: got %0b want 1", bus.miso.arready); end
    endtask

    task automatic test_strobe();
        logic [1:0]  resp;
        logic [31:0] data;
        write_word(16'h0000, 32'h00000000, 4'hF, resp);
        write_word(16'h0000, 32'hAABBCCDD, 4'h5, resp);
        n_checks++; if (resp !== RESP_OKAY) begin n_fail++; $display("FAIL strb_bresp: got %0h want 0", resp); end
        read_word(16'h0000, data, resp);
        n_checks++; if (data !== 32'h00BB00DD) begin n_fail++; $display("FAIL strb_data: got %08h want 00bb00dd", data); end
        $display("strobe: data=%08h", data);
    endtask

    task automatic test_out_of_range();
        logic [1:0]  resp;
        logic [31:0] data;
        write_word(16'h0400, 32'hDEADBEEF, 4'hF, resp);
        n_checks++; if (resp !== RESP_SLVERR) begin n_fail++; $display("FAIL oor_bresp: got %0h want 2", resp); end
        read_word(16'h0000, data, resp);
        n_checks++; if (data !== 32'h00BB00DD) begin n_fail++; $display("FAIL oor_mem_kept: got %08h want 00bb00dd", data); end
        n_checks++; if (resp !== RESP_OKAY) begin n_fail++; $display("FAIL oor_inrange_rresp: got %0h want 0", resp); end
        read_word(16'h0400, data, resp);
        n_checks++; if (data !== 32'h0) begin n_fail++; $display("FAIL oor_rdata: got %08h want 0", data); end
        n_checks++; if (resp !== RESP_SLVERR) begin n_fail++; $display("FAIL oor_rresp: got %0h want 2", resp); end
        $display("out_of_range: rdata=%08h rresp=%0h", data, resp);
    endtask

    task automatic test_len_mismatch();
        logic [4:0]  id;
        logic [1:0]  resp;
        logic [31:0] data;
        write_word(16'h0044, 32'h5555AAAA, 4'hF, resp);
        do_aw(5'd2, 16'h0040, 8'd0, 3'd2, BURST_INCR);
        do_w(32'h01020304, 4'hF, 1'b0);
        do_w(32'h0BADF00D, 4'hF, 1'b1);
        get_b(id, resp);
        n_checks++; if (id !== 5'd2 || resp !== RESP_OKAY) begin n_fail++; $display("FAIL extra_beat_b: got id %0h resp %0h want 2/0", id, resp); end
        read_word(16'h0040, data, resp);
        n_checks++; if (data !== 32'h01020304) begin n_fail++; $display("FAIL extra_beat_w0: got %08h want 01020304", data); end
        read_word(16'h0044, data, resp);
        n_checks++; if (data !== 32'h5555AAAA) begin n_fail++; $display("FAIL extra_beat_w1: got %08h want 5555aaaa", data); end
        do_aw(5'd4, 16'h0048, 8'd3, 3'd2, BURST_INCR);
        do_w(32'h12345678, 4'hF, 1'b1);
        get_b(id, resp);
        n_checks++; if (id !== 5'd4 || resp !== RESP_OKAY) begin n_fail++; $display("FAIL early_last_b: got id %0h resp %0h want 4/0", id, resp); end
        n_checks++; if (bus.miso.awready !== 1'b1) begin n_fail++; $display("FAIL early_last_awready: got %0b want 1", bus.miso.awready); end
        read_word(16'h0048, data, resp);
        n_checks++; if (data !== 32'h12345678) begin n_fail++; $display("FAIL early_last_data: got %08h want 12345678", data); end
        $display("len_mismatch: early-last data=%08h", data);
    endtask

    task automatic test_fixed_same_cycle();
        logic [4:0]  id;
        logic [1:0]  resp;
        logic [31:0] data;
        do_aw(5'd1, 16'h0008, 8'd2, 3'd2, BURST_FIXED);
        do_w(32'hA0A0A0A0, 4'hF, 1'b0);
        do_w(32'hB0B0B0B0, 4'hF, 1'b0);
        do_w(32'hC0C0C0C0, 4'hF, 1'b1);
        get_b(id, resp);
        read_word(16'h0008, data, resp);
        n_checks++; if (data !== 32'hC0C0C0C0) begin n_fail++; $display("FAIL fixed_word2: got %08h want c0c0c0c0", data); end
        read_word(16'h0010, data, resp);
        n_checks++; if (data !== 32'h11111111) begin n_fail++; $display("FAIL fixed_word4: got %08h want 11111111", data); end
        do_aw(5'd1, 16'h0008, 8'd0, 3'd2, BURST_INCR);
        do_ar(5'd1, 16'h0008, 8'd0, 3'd2, BURST_INCR);
        bus.mosi.wdata  = 32'hD0D0D0D0;
        bus.mosi.wstrb  = 4'hF;
        bus.mosi.wlast  = 1'b1;
        bus.mosi.wvalid = 1'b1;
        bus.mosi.rready = 1'b1;
        #1;
        n_checks++; if (bus.miso.wready !== 1'b1 || bus.miso.rvalid !== 1'b1) begin n_fail++; $display("FAIL same_cycle_hs: got wready %0b rvalid %0b want 1/1", bus.miso.wready, bus.miso.rvalid); end
        n_checks++; if (bus.miso.rdata !== 32'hC0C0C0C0) begin n_fail++; $display("FAIL same_cycle_old: got %08h want c0c0c0c0", bus.miso.rdata); end
        tick();
        bus.mosi.wvalid = 1'b0;
        bus.mosi.wlast  = 1'b0;
        bus.mosi.rready = 1'b0;
        get_b(id, resp);
        read_word(16'h0008, data, resp);
        n_checks++; if (data !== 32'hD0D0D0D0) begin n_fail++; $display("FAIL same_cycle_new: got %08h want d0d0d0d0", data); end
        $display("fixed_same_cycle: after write data=%08h", data);
    endtask

    task automatic test_reset_mid_burst();
        logic [1:0]  resp;
        logic [31:0] data;
        do_aw(5'd6, 16'h0020, 8'd3, 3'd2, BURST_INCR);
        do_w(32'h77777777, 4'hF, 1'b0);
        do_w(32'h88888888, 4'hF, 1'b0);
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        n_checks++; if (bus.miso.bvalid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_bvalid: got %0b want 0", bus.miso.bvalid); end
        n_checks++; if (bus.miso.awready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_awready: got %0b want 1", bus.miso.awready); end
        n_checks++; if (bus.miso.wready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_wready: got %0b want 0", bus.miso.wready); end
`ifdef AXI_RAM_STATS_EN
        n_checks++; if (wr_beats !== 32'd0) begin n_fail++; $display("FAIL mid_rst_wr_beats: got %0d want 0", wr_beats); end
        n_checks++; if (rd_beats !== 32'd0) begin n_fail++; $display("FAIL mid_rst_rd_beats: got %0d want 0", rd_beats); end
`endif
        repeat (3) tick();
        n_checks++; if (bus.miso.bvalid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_no_b: got %0b want 0", bus.miso.bvalid); end
        read_word(16'h0010, data, resp);
        n_checks++; if (data !== 32'h11111111) begin n_fail++; $display("FAIL mid_rst_mem_kept: got %08h want 11111111", data); end
        read_word(16'h0020, data, resp);
        n_checks++; if (data !== 32'h77777777) begin n_fail++; $display("FAIL mid_rst_beat0: got %08h want 77777777", data); end
`ifdef AXI_RAM_STATS_EN
        n_checks++; if (rd_beats !== 32'd2) begin n_fail++; $display("FAIL stats_rd_after: got %0d want 2", rd_beats); end
`endif
        $display("reset_mid_burst: beat0 word=%08h", data);
    endtask

    initial begin
        test_reset();
        test_incr_write();
        test_incr_read_stall();
        test_strobe();
        test_out_of_range();
        test_len_mismatch();
        test_fixed_same_cycle();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time %0t exceeded limit", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axi_ram_slave.md
AXI_RAM_SLAVE -- requirements
Module: axi_ram_slave

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default 32, meaning RDATA/WDATA width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, meaning AW/AR address width.
REQ-003 SHALL have parameter ID_W_WIDTH, default 5, meaning AWID/BID width.
REQ-004 SHALL have parameter ID_R_WIDTH, default 5, meaning ARID/RID width.
REQ-005 SHALL have parameter MEM_DEPTH, default 256, meaning storage size in AXI_DATA_WIDTH words (power of two).
REQ-006 SHALL have port ACLK, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port ARESET, input, 1, reset, synchronous and active-high.
REQ-008 SHALL have port s_axi_i, input, axi_mosi_t, carrying AW/W/AR payload and valids plus BREADY/RREADY from one mesh m_axi_o node.
REQ-009 SHALL have port s_axi_o, output, axi_miso_t, carrying AWREADY/WREADY/ARREADY plus B and R payload and valids back to the mesh m_axi_i node.

Function
REQ-010 SHALL run write and read channels as independent FSMs that may be active in the same cycle.
REQ-011 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; AWREADY=1 only in W_IDLE; on AW handshake it latches AWID, AWADDR, AWLEN, AWSIZE, AWBURST and goes to W_DATA.
REQ-012 In W_DATA WREADY SHALL be 1; each W handshake writes bytes enabled by WSTRB to the current word; on a handshake with WLAST=1 the FSM goes to W_RESP.
REQ-013 Beats beyond AWLEN+1 before WLAST SHALL be accepted but not written; an early WLAST SHALL end the burst normally.
REQ-014 In W_RESP BVALID SHALL be 1 with BID=latched AWID and BRESP held stable until BREADY; the handshake returns the FSM to W_IDLE; AW is never accepted before B completes.
REQ-015 Read FSM SHALL have states R_IDLE, R_DATA; ARREADY=1 only in R_IDLE; an AR handshake in cycle N SHALL give RVALID=1 in cycle N+1.
REQ-016 In R_DATA RDATA SHALL be combinationally read from the current word, RID=latched ARID, RLAST=1 on beat ARLEN; one beat per cycle while RREADY=1; RVALID/RDATA/RLAST held stable while RREADY=0.
REQ-017 An R handshake with RLAST=1 SHALL return the read FSM to R_IDLE; the next ARREADY is in the following cycle.
REQ-018 Beat address SHALL advance by 2**AWSIZE (or ARSIZE) bytes for INCR (2'b01), WRAP (2'b10) and reserved (2'b11); it stays constant for FIXED (2'b00).
REQ-019 A SIZE above log2(AXI_DATA_WIDTH/8) SHALL be treated as full width; address arithmetic wraps modulo 2**ADDR_WIDTH.
REQ-020 Word index SHALL be byte address divided by AXI_DATA_WIDTH/8; a beat whose byte address is at or above MEM_DEPTH*AXI_DATA_WIDTH/8 is out of range.
REQ-021 Out-of-range writes SHALL be dropped and make BRESP=SLVERR (2'b10); out-of-range reads SHALL return RDATA=0 with RRESP=SLVERR; all other responses are OKAY (2'b00).
REQ-022 A read and a write to the same word in the same cycle SHALL return the pre-write data; the write is visible from the next cycle.

Reset
REQ-023 ARESET SHALL put both FSMs in IDLE and set AWREADY=1, ARREADY=1, WREADY=0, BVALID=0, RVALID=0, RLAST=0, BRESP=0, RRESP=0, BID=0, RID=0.
REQ-024 Reset mid-burst SHALL abandon the burst with no B or R response; memory contents SHALL NOT be cleared by reset.

Configuration
REQ-025 With AXI_RAM_STATS_EN defined, ports wr_beats_o and rd_beats_o (output, 32 bits) SHALL count written/read data handshakes, reset to 0 and wrap at 2**32.
REQ-026 Without AXI_RAM_STATS_EN, those ports and counters SHALL be absent, and all other behaviour is identical.

Structure
REQ-027 Package axi_ram_pkg SHALL hold the write/read state enums, the OKAY and SLVERR response constants, and the burst-type constants.
REQ-028 Sub-module axi_ram_addr_gen (combinational next-address from address, size and burst) SHALL be instantiated once per channel.

Verification
REQ-029 AW addr 0x0010, len 3, size 2, INCR, id 5; W 0x11111111..0x44444444 with WSTRB 0xF -> words 4..7 written; BID=5, BRESP=OKAY.
REQ-030 AR addr 0x0010, len 3, id 3, RREADY toggled every other cycle -> RDATA 0x11111111..0x44444444 held stable while stalled; RLAST on the 4th beat; RID=3.
REQ-031 Single write to 0x0000 with data 0xAABBCCDD and WSTRB 0x5 over prior 0 -> read of 0x0000 returns 0x00BB00DD.
REQ-032 AW addr 0x0400 (out of range, depth 256) -> BRESP=SLVERR, memory unchanged; AR 0x0400 -> RDATA=0, RRESP=SLVERR.
REQ-033 FIXED write burst len 2 to 0x0008 -> only word 2 holds the last beat; same-cycle read and write of word 2 -> old data returned.
REQ-034 ARESET asserted after 2 of 4 W beats -> BVALID stays 0, AWREADY=1 next cycle; stats counters (when built in) read 0.
